tod_counter_p: RTL

- Parametrised successor to the 8-bit H:M:S counter that feeds the ALU/display path.
- Integrates the tick prescaler with the seconds/minutes/hours chain, so no separate divided clock is needed. All logic runs on CLK100MHZ.
- Adds run/stop control, a validated load handshake, 12/24-hour display mode, and one-cycle rollover strobes for downstream alarm/date logic.
- Internal time is always held in 24-hour binary.

---
 rtl/tod_counter_p.sv | 132 +++++++++++++
 1 files changed

// File: rtl/tod_counter_p.sv
// Time-of-day counter with integrated tick prescaler, run/stop, validated load
// handshake, 12/24-hour display and one-cycle rollover strobes.
module tod_counter_p #(
   parameter int CLK_FREQ_HZ = 100000000,
   parameter int TICK_HZ     = 1,
   parameter int W           = 8
) (
   input  logic         CLK100MHZ,
   input  logic         reset,
   input  logic         run,
   input  logic         mode_12h,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic [W-1:0] load_hours,
   input  logic [W-1:0] load_minutes,
   input  logic [W-1:0] load_seconds,
   output logic         load_err,
   output logic [W-1:0] hours,
   output logic [W-1:0] minutes,
   output logic [W-1:0] seconds,
   output logic         pm,
   output logic         sec_tick,
   output logic         min_wrap,
   output logic         day_wrap
);

   localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
   localparam int PW  = $clog2(DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

   logic [PW-1:0] pre_q, pre_d;
   logic [4:0]    h_q, h_d;
   logic [5:0]    m_q, m_d, s_q, s_d;
   logic          busy_q, busy_d;
   logic          err_q, err_d;
   logic          st_q, st_d, mw_q, mw_d, dw_q, dw_d;
   logic          tick, accept, ld_ok;
   logic [4:0]    h_disp;

   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         pre_q  <= '0;
         h_q    <= '0;
         m_q    <= '0;
         s_q    <= '0;
         busy_q <= 1'b0;
         err_q  <= 1'b0;
         st_q   <= 1'b0;
         mw_q   <= 1'b0;
         dw_q   <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         h_q    <= h_d;
         m_q    <= m_d;
         s_q    <= s_d;
         busy_q <= busy_d;
         err_q  <= err_d;
         st_q   <= st_d;
         mw_q   <= mw_d;
         dw_q   <= dw_d;
      end
   end

   always_comb begin
      tick   = run && (pre_q == PRE_LAST);
      accept = load_valid && !busy_q;
      // Full-width range check: out-of-range upper bits must reject the load.
      ld_ok  = (load_hours <= W'(23)) && (load_minutes <= W'(59)) &&
               (load_seconds <= W'(59));
      pre_d  = pre_q;
      h_d    = h_q;
      m_d    = m_q;
      s_d    = s_q;
      busy_d = accept;
      err_d  = 1'b0;
      st_d   = 1'b0;
      mw_d   = 1'b0;
      dw_d   = 1'b0;
      if (accept && ld_ok) begin
         h_d   = load_hours[4:0];
         m_d   = load_minutes[5:0];
         s_d   = load_seconds[5:0];
         pre_d = '0;
      end else begin
         err_d = accept;
         if (tick) begin
            pre_d = '0;
            st_d  = 1'b1;
            if (s_q == 6'd59) begin
               s_d  = '0;
               mw_d = 1'b1;
               if (m_q == 6'd59) begin
                  m_d = '0;
                  if (h_q == 5'd23) begin
                     h_d  = '0;
                     dw_d = 1'b1;
                  end else begin
                     h_d = h_q + 5'd1;
                  end
               end else begin
                  m_d = m_q + 6'd1;
               end
            end else begin
               s_d = s_q + 6'd1;
            end
         end else if (run) begin
            pre_d = pre_q + PW'(1);
         end
      end
   end

   always_comb begin
      h_disp = h_q;
      if (mode_12h) begin
         if (h_q == 5'd0)
            h_disp = 5'd12;
         else if (h_q > 5'd12)
            h_disp = h_q - 5'd12;
      end
   end

   assign hours      = W'(h_disp);
   assign minutes    = W'(m_q);
   assign seconds    = W'(s_q);
   assign pm         = (h_q >= 5'd12);
   assign load_ready = !busy_q;
   assign load_err   = err_q;
   assign sec_tick   = st_q;
   assign min_wrap   = mw_q;
   assign day_wrap   = dw_q;

endmodule
